// File: rtl/emg_bargraph_pkg.sv
// ----------------------------------------------------------------------------
// emg_bargraph_pkg
// Shared types and helpers for the EMG bar-graph display.
//   peak_state_t : peak-tracker state (IDLE / HOLD / DECAY)
//   thermo       : thermometer pattern, LED i lit when level > i
//   onehot_dot   : single peak-dot LED at index peak-1 (none when peak is 0)
// Both LED helpers return a LED_MAX-wide vector. LED_MAX covers the largest
// legal NLED (2**16). Callers use only the low NLED bits.
// ----------------------------------------------------------------------------
package emg_bargraph_pkg;

  localparam int unsigned LED_MAX = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  function automatic logic [LED_MAX-1:0] thermo(input int unsigned lvl,
                                                input int unsigned nled);
    logic [LED_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < nled; i++) begin
      if (i < LED_MAX && lvl > i) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [LED_MAX-1:0] onehot_dot(input int unsigned pk,
                                                    input int unsigned nled);
    logic [LED_MAX-1:0] r;
    r = '0;
    if (pk != 0 && pk <= nled && pk <= LED_MAX) r[pk-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/emg_bargraph_peak.sv
// ----------------------------------------------------------------------------
// emg_peak_tracker
// Peak-hold / decay tracker for the bar-graph level.
// After a rise, the peak is held for HOLD_CYCLES. It then steps down one LED
// every DECAY_CYCLES until it meets the current level.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   level      in   current bar height 0..NLED
//   peak_level out  held peak height 0..NLED (registered)
//   state      out  tracker state, used by the top for dot blinking
// ----------------------------------------------------------------------------
module emg_peak_tracker
  import emg_bargraph_pkg::*;
#(
  parameter int unsigned NLED         = 8,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned DECAY_CYCLES = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NLED+1)-1:0]  level,
  output logic [$clog2(NLED+1)-1:0]  peak_level,
  output peak_state_t                state
);

  localparam int unsigned LW      = $clog2(NLED + 1);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DECAY_LOAD = CW'(DECAY_CYCLES - 1);

  peak_state_t   state_p2, state_nxt;
  logic [LW-1:0] peak_p2, peak_nxt, peak_dec;
  logic [CW-1:0] cnt_p2, cnt_nxt;

  // ---- stage p2: peak register, one clock behind level ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p2 <= IDLE;
      peak_p2  <= '0;
      cnt_p2   <= '0;
    end else begin
      state_p2 <= state_nxt;
      peak_p2  <= peak_nxt;
      cnt_p2   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p2;
    peak_nxt  = peak_p2;
    cnt_nxt   = cnt_p2;
    peak_dec  = peak_p2 - LW'(1);

    if (level > peak_p2) begin
      // A rise always wins, including over a decay step due this cycle.
      peak_nxt  = level;
      cnt_nxt   = HOLD_LOAD;
      state_nxt = HOLD;
    end else if (state_p2 == HOLD && cnt_p2 == '0) begin
      if (peak_p2 > level) begin
        state_nxt = DECAY;
        cnt_nxt   = DECAY_LOAD;
      end else begin
        state_nxt = IDLE;
      end
    end else if (state_p2 == DECAY && level == peak_p2) begin
      // Level caught up with the falling peak: stop here, never undercut it.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state_p2 == DECAY && cnt_p2 == '0) begin
      peak_nxt = peak_dec;
      if (peak_dec > level) cnt_nxt = DECAY_LOAD;
      else                  state_nxt = IDLE;
    end else if (state_p2 == IDLE && peak_p2 > level) begin
      // Level fell after the hold had already expired: resume decaying.
      state_nxt = DECAY;
      cnt_nxt   = DECAY_LOAD;
    end else if (cnt_p2 != '0) begin
      cnt_nxt = cnt_p2 - CW'(1);
    end
  end

  assign peak_level = peak_p2;
  assign state      = state_p2;

endmodule

// File: rtl/emg_bargraph.sv
// ----------------------------------------------------------------------------
// emg_bargraph
// EMG envelope level display. Registers an envelope sample on d_valid and
// quantises it to a bar height of 0..NLED. Drives a thermometer bar with a
// peak-hold dot overlaid.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   d          in   envelope sample (DW bits)
//   d_valid    in   d is captured when high
//   leds       out  bar | peak dot, leds[0] is the lowest LED
//   level      out  current bar height 0..NLED
//   peak_level out  held peak height 0..NLED
// Optional build macro EMG_BARGRAPH_BLINK_EN:
//   The peak dot blinks at clk / 2**(BLINK_DIV+1) while the peak is decaying.
//   It is steady otherwise. Without the macro, the dot is always steady and no
//   blink counter is built.
// ----------------------------------------------------------------------------
module emg_bargraph
  import emg_bargraph_pkg::*;
#(
  parameter int unsigned DW           = 8,
  parameter int unsigned NLED         = 8,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned DECAY_CYCLES = 5_000_000,
  parameter int unsigned BLINK_DIV    = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DW-1:0]              d,
  input  logic                       d_valid,
  output logic [NLED-1:0]            leds,
  output logic [$clog2(NLED+1)-1:0]  level,
  output logic [$clog2(NLED+1)-1:0]  peak_level
);

  localparam int unsigned LW    = $clog2(NLED + 1);
  localparam int unsigned SHIFT = DW - $clog2(NLED);

  // (s + 1) >> SHIFT in DW+1 bits. All-ones maps to NLED without overflow.
  // This reproduces the legacy thresholds (i+1)*2**DW/NLED - 1.
  function automatic logic [LW-1:0] quantise(input logic [DW-1:0] s);
    logic [DW:0] sum;
    sum = {1'b0, s} + (DW+1)'(1);
    return LW'(sum >> SHIFT);
  endfunction

  logic [DW-1:0]      s_p0;
  logic [LW-1:0]      level_p1;
  logic [LW-1:0]      peak_p2;
  peak_state_t        pk_state_p2;
  logic               blink_on;
  logic               dot_on;
  logic [LED_MAX-1:0] bar_all;
  logic [LED_MAX-1:0] dot_all;

  // ---- stage p0: sample register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        s_p0 <= '0;
    else if (d_valid) s_p0 <= d;
  end

  // ---- stage p1: quantised bar height ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_p1 <= '0;
    else       level_p1 <= quantise(s_p0);
  end

  // ---- stage p2: peak tracker ----
  emg_peak_tracker #(
    .NLED         (NLED),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .DECAY_CYCLES (DECAY_CYCLES)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .level      (level_p1),
    .peak_level (peak_p2),
    .state      (pk_state_p2)
  );

`ifdef EMG_BARGRAPH_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + (BLINK_DIV+1)'(1);
  end

  assign blink_on = blink_cnt[BLINK_DIV];
`else
  assign blink_on = 1'b1;
`endif

  // The dot only blinks while decaying. The bar itself never blinks.
  assign dot_on = (pk_state_p2 != DECAY) | blink_on;

  // The dot is OR-ed into the bar, so it disappears when it sits on the bar top.
  always_comb begin
    bar_all = thermo(32'(level_p1), NLED);
    dot_all = onehot_dot(32'(peak_p2), NLED);
    leds    = '0;
    for (int unsigned i = 0; i < NLED; i++) begin
      leds[i] = bar_all[i] | (dot_on & dot_all[i]);
    end
  end

  assign level      = level_p1;
  assign peak_level = peak_p2;

endmodule

// File: tb/tb_emg_bargraph.sv
// ----------------------------------------------------------------------------
// tb_emg_bargraph
// Directed bench for emg_bargraph.
// Configuration: DW=8, NLED=8, HOLD_CYCLES=10, DECAY_CYCLES=4, default build.
// Inputs are driven on the falling edge. Outputs are checked on the falling
// edge, after the rising edge that updates them.
// ----------------------------------------------------------------------------
module tb_emg_bargraph;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       d_valid;
  logic [7:0] leds;
  logic [3:0] level;
  logic [3:0] peak_level;

  int n_total = 0;
  int n_bad   = 0;

  emg_bargraph #(
    .DW           (8),
    .NLED         (8),
    .HOLD_CYCLES  (10),
    .DECAY_CYCLES (4),
    .BLINK_DIV    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .d_valid    (d_valid),
    .leds       (leds),
    .level      (level),
    .peak_level (peak_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Threshold sweep: samples, bar heights and legacy LED patterns.
  int sw_d    [7] = '{'h1e, 'h1f, 'h3f, 'h5e, 'hdf, 'hfe, 'hff};
  int sw_lvl  [7] = '{0, 1, 2, 2, 7, 7, 8};
  int sw_leds [7] = '{'h00, 'h01, 'h03, 'h03, 'h7f, 'h7f, 'hff};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset applied while a full-scale sample is present.
    reset   = 1'b1;
    d       = 8'hff;
    d_valid = 1'b1;
    repeat (2) tick();
    check("rst_leds",  int'(leds),       0);
    check("rst_level", int'(level),      0);
    check("rst_peak",  int'(peak_level), 0);
    reset = 1'b0;
    tick();
    check("rel_e1_level", int'(level), 0);
    tick();
    check("rel_e2_level", int'(level), 8);
    check("rel_e2_leds",  int'(leds),  'hff);
    tick();
    check("rel_e3_peak",  int'(peak_level), 8);

    // Threshold sweep in ascending order, so the dot stays inside the bar.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      d = 8'(sw_d[k]);
      tick();
      tick();
      check("sweep_level", int'(level), sw_lvl[k]);
      check("sweep_leds",  int'(leds),  sw_leds[k]);
    end

    // Full scale, then a small level: hold for 10 clocks, then decay every 4 clocks.
    do_reset();
    d = 8'hff;
    tick();
    d = 8'h1f;
    for (int t = 2; t <= 50; t++) begin
      tick();
      case (t)
        3: begin
          check("hd_t3_level", int'(level),      1);
          check("hd_t3_peak",  int'(peak_level), 8);
          check("hd_t3_leds",  int'(leds),       'h81);
        end
        12: check("hd_t12_leds", int'(leds),       'h81);
        16: check("hd_t16_peak", int'(peak_level), 8);
        17: begin
          check("dc_t17_peak", int'(peak_level), 7);
          check("dc_t17_leds", int'(leds),       'h41);
        end
        20: check("dc_t20_peak", int'(peak_level), 7);
        21: check("dc_t21_peak", int'(peak_level), 6);
        25: check("dc_t25_peak", int'(peak_level), 5);
        37: begin
          check("dc_t37_peak", int'(peak_level), 2);
          check("dc_t37_leds", int'(leds),       'h03);
        end
        40: check("dc_t40_peak", int'(peak_level), 2);
        41: begin
          check("dc_t41_peak", int'(peak_level), 1);
          check("dc_t41_leds", int'(leds),       'h01);
        end
        50: begin
          check("idle_t50_peak", int'(peak_level), 1);
          check("idle_t50_leds", int'(leds),       'h01);
        end
        default: ;
      endcase
    end

    // A rise during decay restarts a full hold.
    do_reset();
    d = 8'hff;
    tick();
    d = 8'h1f;
    for (int t = 2; t <= 25; t++) tick();
    check("rd_t25_peak", int'(peak_level), 5);
    d = 8'hbf;
    tick();
    d = 8'h1f;
    tick();
    check("rd_t27_level", int'(level),      6);
    check("rd_t27_peak",  int'(peak_level), 5);
    tick();
    check("rd_t28_peak",  int'(peak_level), 6);
    check("rd_t28_leds",  int'(leds),       'h21);
    for (int t = 29; t <= 41; t++) tick();
    check("rd_t41_peak",  int'(peak_level), 6);
    tick();
    check("rd_t42_peak",  int'(peak_level), 5);
    check("rd_t42_leds",  int'(leds),       'h11);

    // With d_valid low, a toggling d must not move the bar.
    d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = (k % 2 == 0) ? 8'hff : 8'h00;
      tick();
      check("novld_level", int'(level), 1);
    end

    // Asynchronous reset during decay, checked before the next rising edge.
    #2 reset = 1'b1;
    #1;
    check("areset_leds",  int'(leds),       0);
    check("areset_level", int'(level),      0);
    check("areset_peak",  int'(peak_level), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_leds", int'(leds),       0);
    check("post_rst_peak", int'(peak_level), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
